watch_time_reporter: RTL and testbench
======================================

// Module: watch_time_reporter
// PURPOSE
//   Reads the watch time counters (hour/min/sec/msec) and serialises them as an ASCII line
//   "HH:MM:SS.CC\r\n" onto a byte-wide valid/ready stream feeding the UART TX path.
//   Sits between the watch datapath outputs and the UART transmitter/TX FIFO. Triggered by a
//   one-cycle request from the UART command decoder or a button.
//   Sends one coherent snapshot per request.
// PARAMETERS
//   SEND_CRLF   1      1: append 8'h0D,8'h0A (13-byte frame); 0: no CR/LF (11-byte frame)
//   TIME_SEP    8'h3A  separator after HH and after MM (':')
//   FRAC_SEP    8'h2E  separator between SS and CC ('.')
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   i_req       in   1  report request pulse; honoured only in IDLE
//   i_hour      in   5  watch hour, binary
//   i_min       in   6  watch minute, binary
//   i_sec       in   6  watch second, binary
//   i_msec      in   7  watch centiseconds, binary
//   o_tx_data   out  8  ASCII byte to UART TX
//   o_tx_valid  out  1  o_tx_data valid
//   i_tx_ready  in   1  UART TX/FIFO can accept a byte
//   o_busy      out  1  frame in progress (state != IDLE)
//   o_done      out  1  one-cycle pulse after the last byte transfers
// BEHAVIOUR
//   Reset (sync): state=IDLE; o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_done=0; byte index=0.
//   States: IDLE -> CONV -> SEND -> IDLE.
//   IDLE: at an edge with i_req=1, register hour/min/sec/msec snapshot; go to CONV.
//   CONV: one cycle; register tens/ones digits of each field; index=0; go to SEND.
//   Digits: tens=v/10, ones=v%10; ASCII = 8'h30 + digit. Any field value >99 saturates to "99".
//   Latency: i_req sampled at edge k -> o_tx_valid=1 from edge k+2 onward.
//   SEND: o_tx_valid=1; o_tx_data = byte[index]:
//     0 H10, 1 H1, 2 TIME_SEP, 3 M10, 4 M1, 5 TIME_SEP, 6 S10, 7 S1, 8 FRAC_SEP,
//     9 C10, 10 C1, 11 8'h0D, 12 8'h0A (11/12 only when SEND_CRLF=1).
//   Transfer = o_tx_valid & i_tx_ready at a clock edge. On transfer index+1; next byte presented
//   the following cycle with o_tx_valid still 1 (back-to-back, one byte per cycle max).
//   While i_tx_ready=0: o_tx_valid stays 1, o_tx_data stable; never drop or retract a byte.
//   Last byte transferred -> IDLE; o_tx_valid=0 and o_done=1 for exactly that next cycle.
//   Snapshot isolation: time inputs changing during CONV/SEND do not affect the frame.
//   i_req while busy (CONV/SEND) is ignored, not queued. i_req in the o_done cycle (IDLE)
//   is accepted.
//   rst mid-frame: the next cycle shows reset values; partial frame abandoned, no o_done.
//   The next frame restarts at byte 0.
//   Index counter width $clog2(13); no wrap beyond the last byte.
// TESTING
//   T1 hour=12,min=0,sec=5,msec=7, i_req, ready=1 -> bytes 31 32 3A 30 30 3A 30 35 2E 30 37 0D 0A
//      on consecutive cycles, valid first at k+2, o_done once after 0A.
//   T2 as T1, ready=0 for 5 cycles while byte 2 is presented -> o_tx_data=3A held for 6 cycles;
//      byte count still 13, order intact.
//   T3 change inputs to 23:59:59.99 one cycle after i_req -> frame still carries 12:00:05.07.
//   T4 pulse i_req 3 times during SEND -> exactly one frame, one o_done; i_req in done cycle
//      -> second full frame.
//   T5 msec=120, sec=63 -> centiseconds "99" (39 39), seconds "63" (36 33); hour=23 -> 32 33.
//   T6 rst after 4 bytes sent -> valid=0, busy=0 next cycle, no o_done; new i_req -> full frame
//      from byte 31. SEND_CRLF=0 build -> 11 bytes, o_done after 8'h37.

Source files
------------

// File: rtl/watch_time_reporter.sv
// Watch time reporter: snapshots hour/min/sec/centisec on request and streams
// the ASCII line "HH:MM:SS.CC" (optionally followed by CR LF) over a byte-wide
// valid/ready interface towards the UART transmitter.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_req; time snapshot is captured on acceptance
// CONV  | one cycle: snapshot converted to decimal digits, index cleared
// SEND  | presenting byte[index]; advances on each valid&ready transfer
module watch_time_reporter #(
    parameter bit         SEND_CRLF = 1'b1,
    parameter logic [7:0] TIME_SEP  = 8'h3A,
    parameter logic [7:0] FRAC_SEP  = 8'h2E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_msec,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_done
);

    localparam int IDX_W = $clog2(13);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEND_CRLF ? 12 : 10);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t state, state_next;

    logic [4:0]       snap_hour;
    logic [5:0]       snap_min;
    logic [5:0]       snap_sec;
    logic [6:0]       snap_msec;
    // digit order: [7]=H10 [6]=H1 [5]=M10 [4]=M1 [3]=S10 [2]=S1 [1]=C10 [0]=C1
    logic [7:0][3:0]  dig;
    logic [IDX_W-1:0] idx;
    logic             transfer;
    logic             last_byte;

    // Two decimal digits of a field; anything above 99 reports as 99.
    function automatic logic [7:0] to_digits(input logic [6:0] v);
        logic [6:0] s;
        s = (v > 7'd99) ? 7'd99 : v;
        return {4'(s / 7'd10), 4'(s % 7'd10)};
    endfunction

    assign transfer   = (state == SEND) && i_tx_ready;
    assign last_byte  = (idx == LAST_IDX);
    assign o_tx_valid = (state == SEND);
    assign o_busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; requests outside IDLE are dropped, not queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req) state_next = CONV;
            CONV:    state_next = SEND;
            SEND:    if (transfer && last_byte) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot capture, digit conversion, byte index and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_hour <= '0;
            snap_min  <= '0;
            snap_sec  <= '0;
            snap_msec <= '0;
            dig       <= '0;
            idx       <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done <= transfer && last_byte;
            if (state == IDLE && i_req) begin
                snap_hour <= i_hour;
                snap_min  <= i_min;
                snap_sec  <= i_sec;
                snap_msec <= i_msec;
            end
            if (state == CONV) begin
                dig <= {to_digits({2'b00, snap_hour}), to_digits({1'b0, snap_min}),
                        to_digits({1'b0, snap_sec}),   to_digits(snap_msec)};
                idx <= '0;
            end
            // index parks on the last byte; CONV clears it for the next frame
            if (transfer && !last_byte) idx <= idx + 1'b1;
        end
    end

    // Byte selection for the current index; zero whenever nothing is offered.
    always_comb begin
        o_tx_data = 8'h00;
        if (state == SEND) begin
            case (idx)
                4'd0:    o_tx_data = 8'h30 + {4'h0, dig[7]};
                4'd1:    o_tx_data = 8'h30 + {4'h0, dig[6]};
                4'd2:    o_tx_data = TIME_SEP;
                4'd3:    o_tx_data = 8'h30 + {4'h0, dig[5]};
                4'd4:    o_tx_data = 8'h30 + {4'h0, dig[4]};
                4'd5:    o_tx_data = TIME_SEP;
                4'd6:    o_tx_data = 8'h30 + {4'h0, dig[3]};
                4'd7:    o_tx_data = 8'h30 + {4'h0, dig[2]};
                4'd8:    o_tx_data = FRAC_SEP;
                4'd9:    o_tx_data = 8'h30 + {4'h0, dig[1]};
                4'd10:   o_tx_data = 8'h30 + {4'h0, dig[0]};
                4'd11:   if (SEND_CRLF) o_tx_data = 8'h0D;
                4'd12:   if (SEND_CRLF) o_tx_data = 8'h0A;
                default: o_tx_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_watch_time_reporter.sv
// Bench for watch_time_reporter: CRLF build is the main device, a no-CRLF
// build runs alongside on the same request and time inputs.
module tb_watch_time_reporter;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst, req, ready, ready0;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [6:0] msec;
    logic [7:0] tx_data, tx_data0;
    logic       tx_valid, busy, done, tx_valid0, busy0, done0;

    int passed = 0;
    int total  = 0;

    watch_time_reporter #(.SEND_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_hour(hour), .i_min(min), .i_sec(sec),
        .i_msec(msec), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_busy(busy), .o_done(done));

    watch_time_reporter #(.SEND_CRLF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i_req(req), .i_hour(hour), .i_min(min), .i_sec(sec),
        .i_msec(msec), .o_tx_data(tx_data0), .o_tx_valid(tx_valid0), .i_tx_ready(ready0),
        .o_busy(busy0), .o_done(done0));

    always #5 clk = ~clk;

    // Reference: the text line a watch would print for these field values.
    function automatic byte_q_t model(input int h, input int m, input int s, input int c,
                                      input bit crlf);
        byte_q_t q;
        int f[4];
        int v;
        f = '{h, m, s, c};
        for (int i = 0; i < 4; i++) begin
            v = (f[i] > 99) ? 99 : f[i];
            q.push_back(8'h30 + 8'(v / 10));
            q.push_back(8'h30 + 8'(v % 10));
            if (i < 2)  q.push_back(8'h3A);
            if (i == 2) q.push_back(8'h2E);
        end
        if (crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    // Called #1 after an edge with the device idle; returns #1 after the sampling edge.
    task automatic send_req(input int h, input int m, input int s, input int c);
        hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
        req  = 1'b1;
        @(posedge clk); #1;
        req  = 1'b0;
    endtask

    // Sink for the main device. Returns #1 after the edge that took the last byte.
    task automatic recv(input int exp_len, input int stall_at, input int stall_len,
                        input int stall_pct, input bit mutate, input bit pulse_req,
                        output byte_q_t got, output int viol, output int hold_cnt,
                        output int early_done, output int first_valid, output int cycles);
        int         rem;
        bit         prev_st;
        logic [7:0] prev_d;
        got = {}; viol = 0; hold_cnt = 0; early_done = 0; first_valid = -1; cycles = 0;
        rem = stall_len; prev_st = 1'b0; prev_d = 8'h00;
        for (int cyc = 0; cyc < 400 && got.size() < exp_len; cyc++) begin
            cycles++;
            if (done) early_done++;
            if (mutate) begin
                hour = 5'($urandom); min = 6'($urandom); sec = 6'($urandom); msec = 7'($urandom);
            end
            if (pulse_req) req = tx_valid && (cyc == 2 || cyc == 4 || cyc == 6);
            if (tx_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (prev_st && tx_data !== prev_d) viol++;
                if (got.size() == stall_at) hold_cnt++;
                if (got.size() == stall_at && rem > 0) begin
                    ready = 1'b0;
                    rem--;
                end else begin
                    ready = ($urandom_range(99) >= stall_pct);
                end
                if (ready) got.push_back(tx_data);
                prev_st = !ready;
                prev_d  = tx_data;
            end else begin
                if (prev_st) viol++;
                ready   = 1'($urandom_range(1));
                prev_st = 1'b0;
            end
            @(posedge clk); #1;
        end
        req   = 1'b0;
        ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", tx_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (tx_valid0 !== 1'b0) $display("FAIL reset_valid0 got %b want 0", tx_valid0); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // T1: plain frame, sink always ready.
    task automatic test_basic();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc;
        exp = model(12, 0, 5, 7, 1'b1);
        send_req(12, 0, 5, 7);
        total++; if (busy !== 1'b1) $display("FAIL t1_busy got %b want 1", busy); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL t1_conv_valid got %b want 0", tx_valid); else passed++;
        recv(13, -1, 0, 0, 1'b0, 1'b0, got, viol, hold, ed, fv, cyc);
        total++; if (fv != 1) $display("FAIL t1_latency got %0d want 1", fv); else passed++;
        total++; if (cyc != 14) $display("FAIL t1_cycles got %0d want 14", cyc); else passed++;
        total++; if (got.size() != 13) $display("FAIL t1_len got %0d want 13", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t1_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL t1_done got done=%b valid=%b busy=%b want 1 0 0", done, tx_valid, busy);
        else passed++;
        total++; if (ed != 0) $display("FAIL t1_early_done got %0d want 0", ed); else passed++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL t1_done_pulse got %b want 0", done); else passed++;
    endtask

    // T2: sink stalls for 5 cycles on byte 2.
    task automatic test_stall();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc;
        exp = model(12, 0, 5, 7, 1'b1);
        send_req(12, 0, 5, 7);
        recv(13, 2, 5, 0, 1'b0, 1'b0, got, viol, hold, ed, fv, cyc);
        total++; if (hold != 6) $display("FAIL t2_hold got %0d want 6", hold); else passed++;
        total++; if (viol != 0) $display("FAIL t2_stable got %0d want 0", viol); else passed++;
        total++; if (got.size() != 13) $display("FAIL t2_len got %0d want 13", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t2_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (done !== 1'b1) $display("FAIL t2_done got %b want 1", done); else passed++;
    endtask

    // T3: inputs churn from the cycle after the request; frame keeps the snapshot.
    task automatic test_snapshot();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc;
        exp = model(12, 0, 5, 7, 1'b1);
        send_req(12, 0, 5, 7);
        recv(13, -1, 0, 25, 1'b1, 1'b0, got, viol, hold, ed, fv, cyc);
        total++; if (got.size() != 13) $display("FAIL t3_len got %0d want 13", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t3_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (viol != 0) $display("FAIL t3_stable got %0d want 0", viol); else passed++;
    endtask

    // T4: requests during SEND dropped; request in the done cycle starts a new frame.
    task automatic test_back_to_back();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc;
        exp = model(1, 2, 3, 4, 1'b1);
        send_req(1, 2, 3, 4);
        recv(13, -1, 0, 0, 1'b0, 1'b1, got, viol, hold, ed, fv, cyc);
        total++; if (got.size() != 13 || got[0] !== exp[0] || got[12] !== exp[12])
            $display("FAIL t4_frame1 got len=%0d want 13", got.size());
        else passed++;
        total++; if (done !== 1'b1 || ed != 0)
            $display("FAIL t4_done1 got done=%b early=%0d want 1 0", done, ed);
        else passed++;
        exp = model(21, 43, 17, 88, 1'b1);
        send_req(21, 43, 17, 88);
        total++; if (busy !== 1'b1) $display("FAIL t4_accept_in_done got busy=%b want 1", busy); else passed++;
        recv(13, -1, 0, 30, 1'b0, 1'b0, got, viol, hold, ed, fv, cyc);
        total++; if (got.size() != 13) $display("FAIL t4_len2 got %0d want 13", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t4_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (done !== 1'b1 || ed != 0)
            $display("FAIL t4_done2 got done=%b early=%0d want 1 0", done, ed);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL t4_no_queued got busy=%b done=%b want 0 0", busy, done);
        else passed++;
    endtask

    // T5 plus random sweep: saturation and general digit conversion under random stalls.
    task automatic test_random();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc, h, m, s, c;
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin
                h = 23; m = 0; s = 63; c = 120;
            end else begin
                h = $urandom_range(31); m = $urandom_range(63);
                s = $urandom_range(63); c = $urandom_range(127);
            end
            exp = model(h, m, s, c, 1'b1);
            send_req(h, m, s, c);
            recv(13, -1, 0, 40, 1'b0, 1'b0, got, viol, hold, ed, fv, cyc);
            total++; if (got.size() != 13) $display("FAIL t5_len%0d got %0d want 13", n, got.size()); else passed++;
            for (int i = 0; i < exp.size(); i++) begin
                total++;
                if (i >= got.size() || got[i] !== exp[i])
                    $display("FAIL t5_f%0d_byte%0d got %h want %h", n, i,
                             (i < got.size()) ? got[i] : 8'hxx, exp[i]);
                else passed++;
            end
            total++; if (viol != 0 || done !== 1'b1)
                $display("FAIL t5_hs%0d got viol=%0d done=%b want 0 1", n, viol, done);
            else passed++;
        end
    endtask

    // T6: reset after four bytes, then a full clean frame.
    task automatic test_reset_mid();
        byte_q_t got, exp;
        int viol, hold, ed, fv, cyc, sent;
        send_req(12, 0, 5, 7);
        ready = 1'b1;
        sent = 0;
        for (int i = 0; i < 30 && sent < 4; i++) begin
            if (tx_valid) sent++;
            @(posedge clk); #1;
        end
        total++; if (sent != 4) $display("FAIL t6_partial got %0d want 4", sent); else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00)
            $display("FAIL t6_after_rst got valid=%b busy=%b done=%b data=%h want 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        else passed++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL t6_no_done got %b want 0", done); else passed++;
        exp = model(9, 30, 45, 99, 1'b1);
        send_req(9, 30, 45, 99);
        recv(13, -1, 0, 0, 1'b0, 1'b0, got, viol, hold, ed, fv, cyc);
        total++; if (got.size() != 13) $display("FAIL t6_len got %0d want 13", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t6_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
    endtask

    // T6b: build without CR/LF ends after the centiseconds.
    task automatic test_no_crlf();
        byte_q_t got, exp;
        int wait_cyc;
        wait_cyc = 0;
        while ((busy || busy0) && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        total++; if (busy0 !== 1'b0) $display("FAIL t7_idle got busy0=%b want 0", busy0); else passed++;
        exp = model(12, 0, 5, 7, 1'b0);
        send_req(12, 0, 5, 7);
        got = {};
        for (int i = 0; i < 60 && got.size() < 11; i++) begin
            if (tx_valid0 && ready0) got.push_back(tx_data0);
            @(posedge clk); #1;
        end
        total++; if (got.size() != 11) $display("FAIL t7_len got %0d want 11", got.size()); else passed++;
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i])
                $display("FAIL t7_byte%0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            else passed++;
        end
        total++; if (done0 !== 1'b1 || tx_valid0 !== 1'b0)
            $display("FAIL t7_done got done=%b valid=%b want 1 0", done0, tx_valid0);
        else passed++;
        wait_cyc = 0;
        while (busy && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; ready = 1'b1; ready0 = 1'b1;
        hour = '0; min = '0; sec = '0; msec = '0;
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_no_crlf();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
